// File: rtl/lut3d_pkg.sv
// Shared constants and types for the 3D-LUT neighbour fetch block.
//   GW        grid index width per axis (17-point grid => 4 bits)
//   GRID      grid points per axis
//   AW        LUT address width (17^3 = 4913 entries)
//   STRIDE_*  address step for +1 along each axis
//   state_e   fetch FSM states
package lut3d_pkg;

  localparam int GW       = 4;
  localparam int GRID     = 17;
  localparam int AW       = 13;
  localparam int STRIDE_R = 1;
  localparam int STRIDE_G = 17;
  localparam int STRIDE_B = 289;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/lut3d_addr_gen.sv
// Combinational LUT address generator for one cube corner.
// Ports:
//   idx_r/g/b  grid indices of the base corner
//   corner     corner number k: bit0 = R+1, bit1 = G+1, bit2 = B+1
//   addr       idx_b*289 + idx_g*17 + idx_r + corner offset
module lut3d_addr_gen
  import lut3d_pkg::*;
#(
  parameter int IW = GW
) (
  input  logic [IW-1:0] idx_r,
  input  logic [IW-1:0] idx_g,
  input  logic [IW-1:0] idx_b,
  input  logic [2:0]    corner,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] r_e, g_e, b_e, base;

  always_comb begin
    r_e  = AW'(idx_r);
    g_e  = AW'(idx_g);
    b_e  = AW'(idx_b);
    // 289 = 256 + 32 + 1, 17 = 16 + 1
    base = (b_e << 8) + (b_e << 5) + b_e + (g_e << 4) + g_e + r_e;
    addr = base
         + (corner[0] ? AW'(STRIDE_R) : '0)
         + (corner[1] ? AW'(STRIDE_G) : '0)
         + (corner[2] ? AW'(STRIDE_B) : '0);
  end

endmodule

// File: rtl/lut3d_nbr_fetch.sv
// Fetches the eight LUT cube corners surrounding a pixel for trilinear
// interpolation.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    pixel handshake, in_pix = {B,G,R}
//   mem_rd_en/mem_addr   LUT read request; mem_rdata valid one cycle later
//   out_valid/out_ready  neighbour-set handshake
//   frac_r/g/b           fractional position per axis
//   pt_nbr[k]            corner k {B,G,R}, k bit0 = R+1, bit1 = G+1, bit2 = B+1
//
// state  | meaning
// IDLE   | ready for a pixel; indices/fracs latched on accept
// ISSUE  | 8 reads, corners 0..7, one per cycle
// DRAIN  | capture data for corner 7
// OUT    | neighbour set presented until out_ready
module lut3d_nbr_fetch #(
  parameter  int IN_CD  = 8,
  parameter  int GW     = 4,
  parameter  int LUT_CD = 8,
  localparam int FW     = IN_CD - GW,
  localparam int AW     = lut3d_pkg::AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3*IN_CD-1:0]  in_pix,
  output logic                mem_rd_en,
  output logic [AW-1:0]       mem_addr,
  input  logic [3*LUT_CD-1:0] mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FW-1:0]       frac_r,
  output logic [FW-1:0]       frac_g,
  output logic [FW-1:0]       frac_b,
  output logic [3*LUT_CD-1:0] pt_nbr [7:0]
);

  import lut3d_pkg::*;

  state_e              state_q, state_d;
  logic [2:0]          k_q;
  logic [GW-1:0]       idx_r_q, idx_g_q, idx_b_q;
  logic [FW-1:0]       frac_r_q, frac_g_q, frac_b_q;
  logic                cap_en_q;
  logic [2:0]          cap_k_q;
  logic [3*LUT_CD-1:0] pt_q [7:0];
  logic [AW-1:0]       corner_addr;

  lut3d_addr_gen #(.IW(GW)) u_addr_gen (
    .idx_r  (idx_r_q),
    .idx_g  (idx_g_q),
    .idx_b  (idx_b_q),
    .corner (k_q),
    .addr   (corner_addr)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    mem_rd_en = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_rd_en = 1'b1;
        if (k_q == 3'd7) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    mem_addr = mem_rd_en ? corner_addr : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      idx_r_q  <= '0;
      idx_g_q  <= '0;
      idx_b_q  <= '0;
      frac_r_q <= '0;
      frac_g_q <= '0;
      frac_b_q <= '0;
      // clearing the capture strobe drops read data still in flight
      cap_en_q <= 1'b0;
      cap_k_q  <= '0;
      for (int i = 0; i < 8; i++) pt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cap_en_q <= mem_rd_en;
      cap_k_q  <= k_q;
      if (state_q == ST_IDLE && in_valid) begin
        idx_r_q  <= in_pix[IN_CD-1 -: GW];
        idx_g_q  <= in_pix[2*IN_CD-1 -: GW];
        idx_b_q  <= in_pix[3*IN_CD-1 -: GW];
        frac_r_q <= in_pix[FW-1:0];
        frac_g_q <= in_pix[IN_CD+FW-1 -: FW];
        frac_b_q <= in_pix[2*IN_CD+FW-1 -: FW];
        k_q      <= '0;
      end else if (state_q == ST_ISSUE) begin
        k_q <= k_q + 3'd1;
      end
      if (cap_en_q) pt_q[cap_k_q] <= mem_rdata;
    end
  end

  assign frac_r = frac_r_q;
  assign frac_g = frac_g_q;
  assign frac_b = frac_b_q;
  assign pt_nbr = pt_q;

endmodule

// File: tb/tb_lut3d_nbr_fetch.sv
module tb_lut3d_nbr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_pix;
  logic        mem_rd_en;
  logic [12:0] mem_addr;
  logic [23:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  frac_r, frac_g, frac_b;
  logic [23:0] pt_nbr [7:0];

  lut3d_nbr_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frac_r    (frac_r),
    .frac_g    (frac_g),
    .frac_b    (frac_b),
    .pt_nbr    (pt_nbr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] pt [8];
    logic [3:0]  fr, fg, fb;
  } exp_t;

  exp_t res_q[$];
  int   addr_q[$];
  int   acc_q[$];

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  last_acc = 0;
  bit  chk_spacing = 0;
  bit  lut_id = 1;
  bit  rand_ready = 0;
  bit  ov_prev = 0;

  function automatic logic [23:0] lut_f(input int a);
    logic [23:0] v;
    v = 24'(a);
    return lut_id ? v : (v ^ (v << 11) ^ 24'h5A5A5A);
  endfunction

  task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // LUT memory: one-cycle read latency, garbage when not read
  always @(posedge clk)
    mem_rdata <= mem_rd_en ? lut_f(int'(mem_addr)) : 24'($urandom);

  // Monitor + scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (mem_rd_en) begin
      if (addr_q.size() == 0) chk("unexpected_rd", 0, mem_addr, -1);
      else begin
        int a;
        a = addr_q.pop_front();
        chk("rd_addr", mem_addr == 13'(a), mem_addr, a);
      end
    end else if (!rst) begin
      chk("idle_addr_zero", mem_addr == 0, mem_addr, 0);
    end
    if (out_valid) begin
      chk("in_ready_in_out", in_ready == 0, in_ready, 0);
      if (res_q.size() == 0) chk("unexpected_out", 0, 1, 0);
      else begin
        if (!ov_prev) chk("latency", cyc - acc_q[0] == 10, cyc - acc_q[0], 10);
        for (int k = 0; k < 8; k++)
          chk($sformatf("pt_nbr[%0d]", k), pt_nbr[k] == res_q[0].pt[k], pt_nbr[k], res_q[0].pt[k]);
        chk("frac_r", frac_r == res_q[0].fr, frac_r, res_q[0].fr);
        chk("frac_g", frac_g == res_q[0].fg, frac_g, res_q[0].fg);
        chk("frac_b", frac_b == res_q[0].fb, frac_b, res_q[0].fb);
        if (out_ready) begin
          void'(res_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
    end
    ov_prev = out_valid;
    if (rst) begin
      res_q.delete();
      addr_q.delete();
      acc_q.delete();
      ov_prev = 0;
    end else if (in_valid && in_ready) begin
      exp_t e;
      int r, g, b, base, a;
      r = int'(in_pix[7:0]);
      g = int'(in_pix[15:8]);
      b = int'(in_pix[23:16]);
      base = (b / 16) * 289 + (g / 16) * 17 + (r / 16);
      for (int k = 0; k < 8; k++) begin
        a = base + (k % 2) + ((k / 2) % 2) * 17 + (k / 4) * 289;
        addr_q.push_back(a);
        e.pt[k] = lut_f(a);
      end
      e.fr = 4'(r % 16);
      e.fg = 4'(g % 16);
      e.fb = 4'(b % 16);
      res_q.push_back(e);
      acc_q.push_back(cyc);
      if (chk_spacing) chk("accept_spacing", cyc - last_acc == 11, cyc - last_acc, 11);
      last_acc = cyc;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [23:0] p);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    in_valid = 1'b1;
    in_pix = p;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", 0, 0, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((res_q.size() != 0 || addr_q.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_timeout", res_q.size() == 0, res_q.size(), 0);
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_in_ready", in_ready == 1, in_ready, 1);
    chk("rst_out_valid", out_valid == 0, out_valid, 0);
    chk("rst_mem_rd_en", mem_rd_en == 0, mem_rd_en, 0);
    chk("rst_mem_addr", mem_addr == 0, mem_addr, 0);
    chk("rst_frac", {frac_b, frac_g, frac_r} == 0, {frac_b, frac_g, frac_r}, 0);
    for (int k = 0; k < 8; k++)
      chk($sformatf("rst_pt_nbr[%0d]", k), pt_nbr[k] == 0, pt_nbr[k], 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_pix = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();

    // corner pixels and the identity-LUT example
    lut_id = 1;
    send(24'h000000); in_valid = 1'b0; wait_done();
    send(24'hFFFFFF); in_valid = 1'b0; wait_done();
    send(24'h123456); in_valid = 1'b0; wait_done();

    // downstream stall for 5 cycles in OUT
    out_ready = 1'b0;
    send(24'($urandom)); in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
    chk("stall_reach_out", out_valid == 1, out_valid, 1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_after_release", in_ready == 1, in_ready, 1);
    wait_done();

    // reset during the 4th ISSUE cycle
    send(24'h89ABCD); in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rd_after_rst", mem_rd_en == 0, mem_rd_en, 0);
    @(posedge clk); #1;
    check_reset_state();
    repeat (15) @(posedge clk);
    #1;
    send(24'($urandom)); in_valid = 1'b0; wait_done();

    // back-to-back pixels with in_valid held high
    lut_id = 0;
    send(24'h0F1E2D);
    chk_spacing = 1;
    send(24'hF0E1D2);
    send(24'h7F807F);
    in_valid = 1'b0;
    chk_spacing = 0;
    wait_done();

    // random pixels, random gaps, random backpressure
    rand_ready = 1;
    for (int i = 0; i < 20; i++) begin
      send(24'($urandom));
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_done();
    rand_ready = 0;
    out_ready = 1'b1;
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
